// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// One quotient bit is resolved per clock.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle between the arithmetic unit
// and the restoring divider.
interface div_if #(
  parameter int N = 8
) ();

  logic         start_i;
  logic [N-1:0] dividend_i;
  logic [N-1:0] divisor_i;
  logic         ready_o;
  logic         busy_o;
  logic         valid_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;
  logic         div_by_zero_o;

  modport slave (
    input  start_i,
    input  dividend_i,
    input  divisor_i,
    output ready_o,
    output busy_o,
    output valid_o,
    output quotient_o,
    output remainder_o,
    output div_by_zero_o
  );

  modport master (
    output start_i,
    output dividend_i,
    output divisor_i,
    input  ready_o,
    input  busy_o,
    input  valid_o,
    input  quotient_o,
    input  remainder_o,
    input  div_by_zero_o
  );

endinterface

// File: rtl/seq_restoring_divider_sub.sv
// Trial subtractor: a + ~b + 1, carry-out high
// means a >= b (no borrow).
module div_sub_stage #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         no_borrow_o
);

  logic [W:0] sum;

  assign sum = {1'b0, a_i}
             + {1'b0, ~b_i}
             + {{W{1'b0}}, 1'b1};

  assign diff_o      = sum[W-1:0];
  assign no_borrow_o = sum[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider,
// one quotient bit per clock.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input logic clk_i,
  input logic rst_i,
  div_if.slave bus
);

  localparam int CW = cnt_width(N);

  div_state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]   r_shift;
  logic [N-1:0] q_shift;
  logic [N:0]   trial;
  logic         no_borrow;
  logic [N:0]   r_next;
  logic [N-1:0] q_next;

  // Restore step keeps R below D, so its top bit never feeds the shift.
  logic unused_r_msb;
  assign unused_r_msb = r_q[N];

  assign r_shift = {r_q[N-1:0], q_q[N-1]};
  assign q_shift = {q_q[N-2:0], 1'b0};

  div_sub_stage #(
    .W(N + 1)
  ) u_sub (
    .a_i        (r_shift),
    .b_i        ({1'b0, d_q}),
    .diff_o     (trial),
    .no_borrow_o(no_borrow)
  );

  assign r_next = no_borrow ? trial : r_shift;
  assign q_next = {q_shift[N-1:1], no_borrow};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start_i) begin
          d_d   = bus.divisor_i;
          q_d   = bus.dividend_i;
          r_d   = '0;
          cnt_d = CW'(N - 1);
          dbz_d = 1'b0;
          if (bus.divisor_i == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend_i;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      (state_q == CALC): begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = q_next;
          rem_d   = r_next[N-1:0];
        end
      end
      (state_q == DONE): begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ready_o       = (state_q == IDLE);
  assign bus.busy_o        = (state_q == CALC);
  assign bus.valid_o       = (state_q == DONE);
  assign bus.quotient_o    = quo_q;
  assign bus.remainder_o   = rem_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule
